// File: rtl/eth_tx_framer_if.sv
// Byte-stream handshake carrying frame bytes (destination MAC first) into the
// Ethernet transmit framer.
interface eth_tx_framer_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: wraps an input byte stream with preamble, SFD, zero
// padding and an IEEE 802.3 FCS; aborts the frame on underflow or overflow.
module eth_tx_framer #(
  parameter int MIN_FRAME  = 60,
  parameter int MAX_FRAME  = 1514,
  parameter int IFG_CYCLES = 12
) (
  input  logic              ETH_CLK,
  input  logic              ETH_RSTn,
  eth_tx_framer_if.slave    s_if,
  output logic [7:0]        gmii_txd,
  output logic              gmii_tx_en,
  output logic              gmii_tx_er,
  output logic              tx_done
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG
  } state_e;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME);
  // IDLE always contributes one quiet cycle before the preamble, so the IFG
  // state itself lasts one cycle less than the required line gap.
  localparam logic [15:0] IFG_LAST = (IFG_CYCLES >= 2) ? 16'(IFG_CYCLES - 2) : 16'd0;

  state_e      state_q;
  logic [15:0] count_q, count_d;
  logic [15:0] step_q;
  logic [31:0] crc_q, crc_d, crc_fcs;
  logic [7:0]  crc_in;
  logic [7:0]  txd_q;
  logic        tx_en_q, tx_er_q, tx_done_q;

  // Reflected CRC-32, one byte per cycle, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_in  = (state_q == DATA) ? s_if.s_data : 8'h00;
    crc_d   = crc32_byte(crc_q, crc_in);
    count_d = count_q + 16'd1;
    crc_fcs = ~crc_q;
  end

  assign s_if.s_ready = (state_q == DATA) || (state_q == DRAIN);

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign tx_done    = tx_done_q;

  // NOTE: every register, line outputs included, is cleared asynchronously so
  // the wire goes quiet the moment ETH_RSTn falls, not at the next edge.
  always_ff @(posedge ETH_CLK or negedge ETH_RSTn) begin
    if (!ETH_RSTn) begin
      state_q   <= IDLE;
      count_q   <= 16'd0;
      step_q    <= 16'd0;
      crc_q     <= CRC_INIT;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the defaults below are overridden by the
      // state arms, and every read sees the pre-edge value.
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      tx_done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          count_q <= 16'd0;
          crc_q   <= CRC_INIT;
          step_q  <= 16'd0;
          if (s_if.s_valid) state_q <= PREAMBLE;
        end

        PREAMBLE: begin
          txd_q   <= 8'h55;
          tx_en_q <= 1'b1;
          if (step_q == 16'd6) begin
            step_q  <= 16'd0;
            state_q <= SFD;
          end else begin
            step_q <= step_q + 16'd1;
          end
        end

        SFD: begin
          txd_q   <= 8'hD5;
          tx_en_q <= 1'b1;
          state_q <= DATA;
        end

        DATA: begin
          // Underflow, or the byte that reaches MAX_FRAME without closing the
          // frame, replaces the line byte with a single error symbol.
          if (!s_if.s_valid || (!s_if.s_last && count_d == MAX_LEN)) begin
            tx_en_q   <= 1'b1;
            tx_er_q   <= 1'b1;
            tx_done_q <= 1'b1;
            step_q    <= 16'd0;
            state_q   <= DRAIN;
          end else begin
            txd_q   <= s_if.s_data;
            tx_en_q <= 1'b1;
            count_q <= count_d;
            crc_q   <= crc_d;
            if (s_if.s_last) state_q <= (count_d < MIN_LEN) ? PAD : FCS;
          end
        end

        PAD: begin
          tx_en_q <= 1'b1;
          count_q <= count_d;
          crc_q   <= crc_d;
          if (count_d >= MIN_LEN) state_q <= FCS;
        end

        FCS: begin
          tx_en_q <= 1'b1;
          case (step_q[1:0])
            2'd0:    txd_q <= crc_fcs[7:0];
            2'd1:    txd_q <= crc_fcs[15:8];
            2'd2:    txd_q <= crc_fcs[23:16];
            default: txd_q <= crc_fcs[31:24];
          endcase
          if (step_q[1:0] == 2'd3) begin
            tx_done_q <= 1'b1;
            step_q    <= 16'd0;
            state_q   <= IFG;
          end else begin
            step_q <= step_q + 16'd1;
          end
        end

        DRAIN: begin
          if (s_if.s_valid && s_if.s_last) begin
            step_q  <= 16'd0;
            state_q <= IFG;
          end
        end

        IFG: begin
          if (step_q >= IFG_LAST) begin
            step_q  <= 16'd0;
            state_q <= IDLE;
          end else begin
            step_q <= step_q + 16'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: table-driven frames plus hand-written
// corner sequences, with a wire-byte scoreboard and an unpadded second instance.
module tb_eth_tx_framer;

  localparam int MIN_FRAME  = 60;
  localparam int MAX_FRAME  = 1514;
  localparam int IFG_CYCLES = 12;

  logic       ETH_CLK = 1'b0;
  logic       ETH_RSTn;
  logic [7:0] gmii_txd, gmii_txd_np;
  logic       gmii_tx_en, gmii_tx_er, tx_done;
  logic       gmii_tx_en_np, gmii_tx_er_np, tx_done_np;

  eth_tx_framer_if s_if ();
  eth_tx_framer_if s2_if ();

  eth_tx_framer #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME), .IFG_CYCLES(IFG_CYCLES)) dut (
    .ETH_CLK    (ETH_CLK),
    .ETH_RSTn   (ETH_RSTn),
    .s_if       (s_if),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .tx_done    (tx_done)
  );

  eth_tx_framer #(.MIN_FRAME(0), .MAX_FRAME(MAX_FRAME), .IFG_CYCLES(IFG_CYCLES)) dut_np (
    .ETH_CLK    (ETH_CLK),
    .ETH_RSTn   (ETH_RSTn),
    .s_if       (s2_if),
    .gmii_txd   (gmii_txd_np),
    .gmii_tx_en (gmii_tx_en_np),
    .gmii_tx_er (gmii_tx_er_np),
    .tx_done    (tx_done_np)
  );

  always #5 ETH_CLK = ~ETH_CLK;

  typedef struct {
    string name;
    int    len;
    int    drop_after;  // -1: no underflow
    int    exp_en;      // tx_en cycles for the whole frame
    bit    exp_err;
  } vec_t;

  int         checks = 0, failures = 0;
  logic [9:0] exp_q[$];   // {tx_done, tx_er, txd}
  logic [9:0] cap2_q[$];
  logic [7:0] pay[$];
  int         cyc = 0, run_len = 0, last_run = 0, idle_run = 0, last_gap = 0;
  int         first_en_cyc = 0, valid_cyc = 0;
  vec_t       vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (bound expired)", name);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < 8; b++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0] ^ d[b]}});
    return c;
  endfunction

  // Expected wire image for the first n_wire bytes of pay[].
  task automatic push_frame(input int n_wire, input bit err);
    logic [31:0] crc;
    int          nbody;
    for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hD5});
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n_wire; i++) begin
      exp_q.push_back({2'b00, pay[i]});
      crc = crc_step(crc, pay[i]);
    end
    if (err) begin
      exp_q.push_back({2'b11, 8'h00});
    end else begin
      nbody = n_wire;
      while (nbody < MIN_FRAME) begin
        exp_q.push_back(10'h000);
        crc = crc_step(crc, 8'h00);
        nbody++;
      end
      crc = ~crc;
      exp_q.push_back({2'b00, crc[7:0]});
      exp_q.push_back({2'b00, crc[15:8]});
      exp_q.push_back({2'b00, crc[23:16]});
      exp_q.push_back({2'b10, crc[31:24]});
    end
  endtask

  task automatic wait_ready(input bit sel);
    int g = 0;
    @(negedge ETH_CLK);
    while (!(sel ? s2_if.s_ready : s_if.s_ready) && g < 4000) begin
      @(negedge ETH_CLK);
      g++;
    end
    if (g >= 4000) fail_now("ready_wait");
  endtask

  // Drives pay[0..n-1], s_last on the final byte; optionally withholds
  // s_valid for one DATA cycle just before byte drop_after. Leaves s_valid high.
  task automatic send(input int n, input int drop_after);
    valid_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = pay[i];
      s_if.s_last  = (i == n - 1);
      if (i == drop_after) begin
        wait_ready(1'b0);
        s_if.s_valid = 1'b0;
        @(posedge ETH_CLK); #1;
        s_if.s_valid = 1'b1;
      end
      wait_ready(1'b0);
      @(posedge ETH_CLK); #1;
    end
    s_if.s_last = 1'b0;
  endtask

  task automatic idle();
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic align();
    repeat (20) @(posedge ETH_CLK);
    #1;
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic finish_frame(input string name, input int exp_en);
    int g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(negedge ETH_CLK);
      g++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (2) @(negedge ETH_CLK);
    check({name, "_en_cycles"}, last_run, exp_en);
  endtask

  initial forever begin
    @(posedge ETH_CLK);
    cyc++;
  end

  // Wire monitor / scoreboard for the default-parameter instance.
  initial forever begin
    @(negedge ETH_CLK);
    if (!ETH_RSTn) begin
      run_len  = 0;
      idle_run = 0;
    end else if (gmii_tx_en) begin
      if (run_len == 0) begin
        last_gap     = idle_run;
        first_en_cyc = cyc;
      end
      run_len++;
      idle_run = 0;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wire_extra got=%0h want=none", {tx_done, gmii_tx_er, gmii_txd});
      end else begin
        check("wire", {tx_done, gmii_tx_er, gmii_txd}, exp_q.pop_front());
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      idle_run++;
      check("idle_out", {tx_done, gmii_tx_er, gmii_txd}, 10'h000);
    end
  end

  initial forever begin
    @(negedge ETH_CLK);
    if (ETH_RSTn && gmii_tx_en_np) cap2_q.push_back({tx_done_np, gmii_tx_er_np, gmii_txd_np});
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fcs_ref;
    logic [9:0]  exp2;
    logic        en_seen;
    int          g;

    vecs[0] = '{"len14",      14, -1, 72, 1'b0};
    vecs[1] = '{"len1",        1, -1, 72, 1'b0};
    vecs[2] = '{"len59",      59, -1, 72, 1'b0};
    vecs[3] = '{"len60",      60, -1, 72, 1'b0};
    vecs[4] = '{"len61",      61, -1, 73, 1'b0};
    vecs[5] = '{"under5",      8,  5, 14, 1'b1};
    vecs[6] = '{"under0",      4,  0,  9, 1'b1};
    vecs[7] = '{"under_last",  6,  5, 14, 1'b1};

    s_if.s_valid = 1'b0;  s_if.s_last = 1'b0;  s_if.s_data = 8'h00;
    s2_if.s_valid = 1'b0; s2_if.s_last = 1'b0; s2_if.s_data = 8'h00;

    ETH_RSTn = 1'b1;
    #1 ETH_RSTn = 1'b0;
    #1;
    check("rst_txd",   gmii_txd,     0);
    check("rst_en",    gmii_tx_en,   0);
    check("rst_er",    gmii_tx_er,   0);
    check("rst_done",  tx_done,      0);
    check("rst_ready", s_if.s_ready, 0);
    repeat (3) @(negedge ETH_CLK);
    ETH_RSTn = 1'b1;

    foreach (vecs[k]) begin
      fill_pay(vecs[k].len);
      push_frame((vecs[k].drop_after >= 0) ? vecs[k].drop_after : vecs[k].len, vecs[k].exp_err);
      align();
      send(vecs[k].len, vecs[k].drop_after);
      idle();
      finish_frame(vecs[k].name, vecs[k].exp_en);
      check({vecs[k].name, "_latency"}, first_en_cyc - valid_cyc, 2);
    end

    // Longest legal frame: no pad, no abort.
    fill_pay(MAX_FRAME);
    push_frame(MAX_FRAME, 1'b0);
    align();
    send(MAX_FRAME, -1);
    idle();
    finish_frame("max_frame", 8 + MAX_FRAME + 4);

    // One byte too many: error replaces byte MAX_FRAME, last byte drained.
    fill_pay(MAX_FRAME + 1);
    push_frame(MAX_FRAME - 1, 1'b1);
    align();
    send(MAX_FRAME + 1, -1);
    idle();
    finish_frame("overflow", 8 + MAX_FRAME);
    check("overflow_ready_low", s_if.s_ready, 0);

    // Back-to-back frames with s_valid held high.
    fill_pay(20);
    push_frame(20, 1'b0);
    align();
    send(20, -1);
    push_frame(20, 1'b0);
    send(20, -1);
    idle();
    finish_frame("b2b", 72);
    check("b2b_gap", last_gap, IFG_CYCLES);

    // Underflow, one drain cycle, then the gap before the next frame.
    fill_pay(6);
    push_frame(5, 1'b1);
    align();
    send(6, 5);
    push_frame(6, 1'b0);
    send(6, -1);
    idle();
    finish_frame("err_then_frame", 72);
    check("err_gap", last_gap, 1 + IFG_CYCLES);

    // Reset while padding: outputs drop at once, no restart without s_valid.
    fill_pay(10);
    push_frame(10, 1'b0);
    align();
    send(10, -1);
    idle();
    repeat (5) @(posedge ETH_CLK);
    #2 ETH_RSTn = 1'b0;
    #1;
    check("rst_pad_en",    gmii_tx_en,   0);
    check("rst_pad_txd",   gmii_txd,     0);
    check("rst_pad_done",  tx_done,      0);
    check("rst_pad_ready", s_if.s_ready, 0);
    exp_q.delete();
    repeat (3) @(negedge ETH_CLK);
    ETH_RSTn = 1'b1;
    en_seen = 1'b0;
    repeat (20) begin
      @(negedge ETH_CLK);
      en_seen = en_seen | gmii_tx_en;
    end
    check("rst_no_restart", en_seen, 0);
    fill_pay(14);
    push_frame(14, 1'b0);
    align();
    send(14, -1);
    idle();
    finish_frame("after_rst", 72);

    // Unpadded instance, "123456789" -> FCS 0xCBF43926.
    cap2_q.delete();
    @(posedge ETH_CLK); #1;
    for (int i = 0; i < 9; i++) begin
      s2_if.s_valid = 1'b1;
      s2_if.s_data  = 8'(8'h31 + i);
      s2_if.s_last  = (i == 8);
      wait_ready(1'b1);
      @(posedge ETH_CLK); #1;
    end
    s2_if.s_valid = 1'b0;
    s2_if.s_last  = 1'b0;
    g = 0;
    while (cap2_q.size() < 21 && g < 200) begin
      @(negedge ETH_CLK);
      g++;
    end
    repeat (3) @(negedge ETH_CLK);
    check("np_len", cap2_q.size(), 21);
    fcs_ref = 32'hCBF43926;
    for (int i = 0; i < 21; i++) begin
      if (i < 7)       exp2 = {2'b00, 8'h55};
      else if (i == 7) exp2 = {2'b00, 8'hD5};
      else if (i < 17) exp2 = {2'b00, 8'(8'h31 + i - 8)};
      else             exp2 = {(i == 20), 1'b0, fcs_ref[8*(i-17) +: 8]};
      if (i < cap2_q.size()) check("np_wire", cap2_q[i], exp2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
